// File: rtl/mem_arbiter.sv
// Arbitrates the single line-wide memory port between the I-cache and D-cache.
// Round-robin per transaction, plus a write-back lock that keeps a victim write and its refill adjacent.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int LOCK_WB = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  grant_cnt_i,
  output logic [CNT_W-1:0]  grant_cnt_d,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a cache holds read/write, addr and wdata level until it sees its one-cycle
  // ready pulse; dropping the request earlier aborts the transaction.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
  typedef enum logic [1:0] {LOCK_NONE = 2'd0, LOCK_I = 2'd1, LOCK_D = 2'd2} lock_t;

  state_t           r_state, w_state_nxt;
  lock_t            r_lock, w_lock_nxt;
  logic             r_last_d, w_last_d_nxt;
  logic [CNT_W-1:0] r_cnt_i, r_cnt_d;
  logic             w_req_i, w_req_d, w_done_i, w_done_d;

  assign w_req_i = i_mem_read | i_mem_write;
  assign w_req_d = d_mem_read | d_mem_write;

  always_comb begin
    w_state_nxt  = r_state;
    w_lock_nxt   = r_lock;
    w_last_d_nxt = r_last_d;
    w_done_i     = 1'b0;
    w_done_d     = 1'b0;
    case (r_state)
      IDLE: begin
        // A lock survives exactly one IDLE cycle: used by its owner or dropped.
        w_lock_nxt = LOCK_NONE;
        if (r_lock == LOCK_I && w_req_i)             w_state_nxt = BUSY_I;
        else if (r_lock == LOCK_D && w_req_d)        w_state_nxt = BUSY_D;
        else if (w_req_i && (!w_req_d || r_last_d))  w_state_nxt = BUSY_I;
        else if (w_req_d)                            w_state_nxt = BUSY_D;
        if (w_state_nxt == BUSY_I)      w_last_d_nxt = 1'b0;
        else if (w_state_nxt == BUSY_D) w_last_d_nxt = 1'b1;
      end
      BUSY_I: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
          w_done_i    = 1'b1;
          if (LOCK_WB != 0 && i_mem_write) w_lock_nxt = LOCK_I;
        end else if (!w_req_i) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
          w_done_d    = 1'b1;
          if (LOCK_WB != 0 && d_mem_write) w_lock_nxt = LOCK_D;
        end else if (!w_req_d) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state  <= IDLE;
      r_lock   <= LOCK_NONE;
      r_last_d <= 1'b1;
      r_cnt_i  <= '0;
      r_cnt_d  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lock   <= w_lock_nxt;
      r_last_d <= w_last_d_nxt;
      if (w_done_i && r_cnt_i != '1) r_cnt_i <= r_cnt_i + 1'b1;
      if (w_done_d && r_cnt_d != '1) r_cnt_d <= r_cnt_d + 1'b1;
    end
  end

  // Write wins when a cache asserts read and write together.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (r_state)
      BUSY_I: begin
        mem_write   = i_mem_write;
        mem_read    = i_mem_read & ~i_mem_write;
        mem_addr    = i_mem_addr;
        mem_wdata   = i_mem_wdata;
        i_mem_ready = mem_ready;
      end
      BUSY_D: begin
        mem_write   = d_mem_write;
        mem_read    = d_mem_read & ~d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
      end
      default: ;
    endcase
  end

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign grant_cnt_i = r_cnt_i;
  assign grant_cnt_d = r_cnt_d;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit line-wide memory port between the instruction cache and the data cache.
- Each cache drives the same level-held request / one-cycle mem_ready protocol it would use against memory directly.
- Selects one cache per transaction using round-robin, with a write-back lock so a dirty-victim write and its refill read stay back-to-back.
- Forwards the granted cache's signals to memory and routes mem_ready back to the granted cache only.

Parameters:
- ADDR_W, 28, line address width.
- LINE_W, 128, line data width.
- LOCK_WB, 1, when 1 a requester whose write just completed keeps priority for its next request.
- CNT_W, 16, width of the saturating grant counters.

Ports:
- clk  in  1  clock
- proc_reset  in  1  asynchronous active-high reset
- i_mem_read  in  1  I-cache read request
- i_mem_write  in  1  I-cache write request
- i_mem_addr  in  ADDR_W  I-cache line address
- i_mem_wdata  in  LINE_W  I-cache write line
- i_mem_rdata  out  LINE_W  read line to I-cache
- i_mem_ready  out  1  completion pulse to I-cache
- d_mem_read  in  1  D-cache read request
- d_mem_write  in  1  D-cache write request
- d_mem_addr  in  ADDR_W  D-cache line address
- d_mem_wdata  in  LINE_W  D-cache write line
- d_mem_rdata  out  LINE_W  read line to D-cache
- d_mem_ready  out  1  completion pulse to D-cache
- mem_read  out  1  read request to memory
- mem_write  out  1  write request to memory
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  LINE_W  write line to memory
- mem_rdata  in  LINE_W  read line from memory
- mem_ready  in  1  memory completion pulse
- grant_cnt_i  out  CNT_W  transactions completed for I-cache, saturating
- grant_cnt_d  out  CNT_W  transactions completed for D-cache, saturating

Behaviour:
- Reset: proc_reset clears everything immediately, regardless of clk or state.
  - state=IDLE, last_grant=D (so I wins the first tie), lock=none.
  - Counters = 0.
  - mem_read, mem_write, mem_addr, mem_wdata, i_mem_ready, d_mem_ready are all 0.
  - Reset mid-transaction abandons the memory request; the memory is also reset by proc_reset.
- Request terms: req_x = x_mem_read | x_mem_write.
- States: IDLE, BUSY_I, BUSY_D (registered).
- IDLE selection:
  - If lock=x and req_x: grant x.
  - Else if only one cache requests: grant it.
  - Else if both request: grant the one that is not last_grant.
  - Else: stay in IDLE.
- Grant timing:
  - The grant is registered; memory sees the request the cycle after the cache first asserts it.
  - Arbitration latency is exactly 1 cycle.
  - In IDLE all mem_* outputs are 0.
  - Entering BUSY_x sets last_grant=x and clears lock.
- BUSY_x forwarding:
  - mem_read, mem_write, mem_addr, mem_wdata are combinational copies of the x_* inputs.
  - If x asserts read and write together, mem_write=1 and mem_read=0.
  - x_mem_ready = mem_ready; the other cache's ready is 0.
- Read data: i_mem_rdata = d_mem_rdata = mem_rdata at all times; only the ready pulse qualifies it.
- Completion: mem_ready=1 in BUSY_x →
  - next state IDLE;
  - grant_cnt_x increments, saturating at 2^CNT_W-1;
  - if LOCK_WB=1 and the completed transaction was a write, lock=x.
- Lock lifetime:
  - lock is consumed by the next grant of any requester.
  - lock is cleared if req_x is low in the first IDLE cycle after it was set, so a lock never blocks an unrelated requester.
- Abort: if req_x drops in BUSY_x without mem_ready, go to IDLE next cycle with no count and no lock. Memory outputs follow the inputs and so drop the same cycle.
- Memory readiness: mem_ready in IDLE is ignored. mem_ready arriving in the same cycle as a request drop is treated as a completion.
- Minimum gap: at least one IDLE cycle separates consecutive memory transactions, so the cache's post-ready state update is always seen before re-arbitration.
- Starvation: with both caches continuously requesting, grants alternate I, D, I, D... except for LOCK_WB refills.

Test Plan:
- Single read: after reset, d_mem_read=1 with addr 0x0000010. Memory answers 3 cycles after mem_read rises with 0xA5..A5 → mem_read rises 1 cycle after the request; d_mem_ready pulses once; i_mem_ready stays 0; grant_cnt_d=1.
- Tie: i_mem_read and d_mem_read rise in the same cycle with memory latency 2 → I served first, then D after one IDLE cycle; next tie → I again, since last_grant=D.
- Write-back lock: D writes 0x0000020 then reads 0x0000030; I requests during D's write → D's read is granted before I; grant_cnt_d=2, then I served.
- Lock disabled (LOCK_WB=0), same stimulus → I served between D's write and D's read.
- Async reset: assert proc_reset mid BUSY_I between clock edges → mem_read=0 and all counts 0 immediately, before the next clk edge; after release, state is IDLE.
- Saturation with CNT_W=4: 20 I-cache transactions → grant_cnt_i holds at 15.
